// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cla_pkg;

  // Width of one lookahead group; operand widths are built from whole groups.
  localparam int GROUP_W = 4;

  // Group generate / propagate pair passed from a group to the inter-group chain.
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: per-bit carries plus group generate/propagate.
// Latency: purely combinational.
// Backpressure: none, no state.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_g,
  input  logic [GROUP_W-1:0] i_p,
  input  logic               i_cin,
  output logic [GROUP_W-1:0] o_c,
  output pg_t                o_pg
);

  // Every carry is flattened to two logic levels from g/p/cin; no ripple inside the group.
  assign o_c[0] = i_cin;
  assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);

  // Group terms let the next group form its carry-in without waiting on o_c[3].
  assign o_pg.g = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_pg.p = &i_p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder: S1 registers g/p/h, S2 resolves carries and registers sum.
// Latency: 2 cycles from input transfer to out_valid; 1 result/cycle when out_ready stays high.
// Backpressure: each stage advances when the next is empty or draining; in_ready is low in reset.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP_W;

  // Refuse to elaborate a width that does not split into whole lookahead groups.
  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4");
  end

  // Stage 1 state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_h;
  logic             r_cin;

  // Stage 2 (output) state
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Handshake and carry network
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [NGRP:0]    w_gc;
  logic [WIDTH-1:0] w_c;
  pg_t              w_pg [NGRP];
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // A stage may take new data if it is empty or its content leaves this cycle.
  assign w_s2_adv = !r_s2_valid | out_ready;
  assign w_s1_adv = !r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv & !rst;

  // Lookahead inside each group, group carry chained between groups.
  assign w_gc[0] = r_cin;
  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla_group4 u_grp (
      .i_g   (r_g[k*GROUP_W +: GROUP_W]),
      .i_p   (r_p[k*GROUP_W +: GROUP_W]),
      .i_cin (w_gc[k]),
      .o_c   (w_c[k*GROUP_W +: GROUP_W]),
      .o_pg  (w_pg[k])
    );
    assign w_gc[k+1] = w_pg[k].g | (w_pg[k].p & w_gc[k]);
  end

  assign w_sum  = r_h ^ w_c;
  assign w_cout = w_gc[NGRP];
  assign w_ovf  = w_c[WIDTH-1] ^ w_gc[NGRP];

  // Stage 1: capture per-bit generate/propagate/half-sum on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_g        <= '0;
      r_p        <= '0;
      r_h        <= '0;
      r_cin      <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_g   <= a & b;
        r_p   <= a | b;
        r_h   <= a ^ b;
        r_cin <= c_in;
      end
    end
  end

  // Stage 2: register the resolved sum; a new load takes priority over going empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks of cla_pipe_adder against an independent arithmetic model.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 2 units after it.
// Each task does its own comparisons; the summary line reports totals.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int checks;
  int failures;

  cla_pipe_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {sum, c_out, ovf}: plain integer add; signed overflow when the operand
  // signs agree and the result sign differs.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc);
    logic [16:0] s;
    logic        v;
    s = {1'b0, ma} + {1'b0, mb} + {16'b0, mc};
    v = (ma[15] == mb[15]) && (s[15] != ma[15]);
    return {s[15:0], s[16], v};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h want=0000", sum); end
    checks++; if ({c_out, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b want=00", c_out, ovf); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; c_in = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b want=0", out_valid); end
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_out_valid got=%b want=1", out_valid); end
    checks++; if ({sum, c_out, ovf} !== {16'h0003, 1'b0, 1'b0}) begin
      failures++; $display("FAIL lat_result got=%h/%b/%b want=0003/0/0", sum, c_out, ovf);
    end
  endtask

  task automatic test_vectors();
    // {a, b, c_in, sum, c_out, ovf}
    logic [50:0] tv [9];
    logic [50:0] t;
    tv = '{
      {16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0},
      {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
      {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1},
      {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
      {16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
      {16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0},
      {16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1},
      {16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0},
      {16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}
    };
    for (int i = 0; i < 9; i++) begin
      t = tv[i];
      @(posedge clk); #1;
      in_valid = 1'b1; a = t[50:35]; b = t[34:19]; c_in = t[18]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (out_valid !== 1'b1 || {sum, c_out, ovf} !== t[17:0]) begin
        failures++;
        $display("FAIL vec%0d got=v%b %h/%b/%b want=v1 %h/%b/%b", i, out_valid, sum, c_out, ovf,
                 t[17:2], t[1], t[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_q [8];
    int nout;
    nout = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (k < 8) begin
        in_valid = 1'b1;
        a = 16'h1111 * 16'(k + 1);
        b = 16'hF00F ^ 16'(k << 5);
        c_in = k[0];
        exp_q[k] = model(a, b, c_in);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b want=1", k, in_ready); end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (nout >= 8) begin
          failures++; $display("FAIL b2b_extra got=%0d results want=8", nout + 1);
        end else if ({sum, c_out, ovf} !== exp_q[nout] || k != nout + 2) begin
          failures++;
          $display("FAIL b2b_res%0d got=%h/%b/%b at cycle %0d want=%h/%b/%b at cycle %0d", nout,
                   sum, c_out, ovf, k, exp_q[nout][17:2], exp_q[nout][1], exp_q[nout][0], nout + 2);
        end
        nout++;
      end
    end
    checks++; if (nout != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", nout); end
  endtask

  task automatic test_stall();
    logic [17:0] exp_q [2];
    logic [15:0] held;
    int acc;
    int got;
    bit  seen;
    acc = 0; seen = 0; held = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1;
      a = 16'h1000 + 16'(acc); b = 16'h0200 * 16'(acc + 1); c_in = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        if (acc < 2) exp_q[acc] = model(a, b, c_in);
        acc++;
      end
      if (k >= 2) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready k=%0d got=%b want=0", k, in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid k=%0d got=%b want=1", k, out_valid); end
      end
      if (out_valid === 1'b1) begin
        if (!seen) begin
          held = sum; seen = 1;
        end else begin
          checks++; if (sum !== held) begin failures++; $display("FAIL stall_hold k=%0d got=%h want=%h", k, sum, held); end
        end
      end
    end
    checks++; if (acc != 2) begin failures++; $display("FAIL stall_accepted got=%0d want=2", acc); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 2) begin
          failures++; $display("FAIL stall_dup got=%0d results want=2", got + 1);
        end else if ({sum, c_out, ovf} !== exp_q[got]) begin
          failures++;
          $display("FAIL stall_res%0d got=%h/%b/%b want=%h/%b/%b", got, sum, c_out, ovf,
                   exp_q[got][17:2], exp_q[got][1], exp_q[got][0]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got != 2) begin failures++; $display("FAIL stall_released got=%0d want=2", got); end
  endtask

  task automatic test_reset_flush();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; a = 16'hABCD; b = 16'(k); c_in = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale k=%0d got=%b want=0", k, out_valid); end
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0100; b = 16'h0023; c_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (out_valid !== 1'b1 || {sum, c_out, ovf} !== {16'h0124, 1'b0, 1'b0}) begin
      failures++; $display("FAIL flush_after got=v%b %h/%b/%b want=v1 0124/0/0", out_valid, sum, c_out, ovf);
    end
  endtask

  task automatic test_random();
    logic [17:0] q [$];
    logic [17:0] e;
    logic [17:0] prev;
    bit  prev_stall;
    int  sent;
    int  got;
    int  cyc;
    localparam int N = 2000;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; prev = '0;
    while (got < N && cyc < 20000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < N) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {sum, c_out, ovf} !== prev) begin
          failures++; $display("FAIL rand_hold cyc=%0d got=v%b %h want=v1 %h", cyc, out_valid, sum, prev[17:2]);
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev = {sum, c_out, ovf};
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in));
        sent++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_unexpected cyc=%0d got=%h want=none", cyc, sum);
        end else begin
          e = q.pop_front();
          if ({sum, c_out, ovf} !== e) begin
            failures++;
            $display("FAIL rand_res%0d got=%h/%b/%b want=%h/%b/%b", got, sum, c_out, ovf, e[17:2], e[1], e[0]);
          end
        end
        got++;
      end
      cyc++;
    end
    checks++; if (got != N) begin failures++; $display("FAIL rand_timeout got=%0d want=%0d", got, N); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
